// File: rtl/pc_address_unit_pkg.sv
// Shared decode/address-unit definitions: address-source encodings,
// default reset-vector location and the fetch FSM state type.
package pc_address_unit_pkg;

    // Address bus source selected by decode
    typedef enum logic [1:0] {
        ASEL_PC     = 2'd0,
        ASEL_MEM    = 2'd1,
        ASEL_ALU    = 2'd2,
        ASEL_PC_ALT = 2'd3
    } asel_e;

    // Location of the reset-vector low byte (high byte follows at +1)
    localparam logic [15:0] DEFAULT_VECTOR_ADDR = 16'hFFFC;

    // Reset-vector fetch sequence followed by normal execution
    typedef enum logic [1:0] {
        S_VEC_LO = 2'd0,
        S_VEC_HI = 2'd1,
        S_RUN    = 2'd2
    } state_e;

endpackage

// File: rtl/pc_address_unit_if.sv
// Decode-side bus of the PC/address unit. Decode owns the master modport,
// the address unit owns the slave modport.
interface pc_address_unit_if;

    logic        clk_enable;
    logic        pc_enable;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic [1:0]  address_select;
    logic [15:0] memory_address;
    logic [7:0]  alu_result;
    logic        rw_in;
    logic [7:0]  data_in;
    logic [15:0] address_out;
    logic        rw_out;
    logic [15:0] pc;
    logic        core_hold;

    modport master (
        output clk_enable, pc_enable, pc_load, pc_load_value, address_select,
               memory_address, alu_result, rw_in, data_in,
        input  address_out, rw_out, pc, core_hold
    );

    modport slave (
        input  clk_enable, pc_enable, pc_load, pc_load_value, address_select,
               memory_address, alu_result, rw_in, data_in,
        output address_out, rw_out, pc, core_hold
    );

endinterface

// File: rtl/pc_address_unit_pc_register.sv
// 16-bit program counter with byte latches for the reset-vector fetch,
// jump load and modulo-2^16 increment. All updates qualified by en_i.
module pc_register #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        latch_lo_i,
    input  logic        latch_hi_i,
    input  logic        load_i,
    input  logic        inc_i,
    input  logic [15:0] load_value_i,
    input  logic [7:0]  data_i,
    output logic [15:0] pc_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    // Next PC: byte latches, then load, then increment
    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            if (latch_lo_i) begin
                pc_d = {pc_q[15:8], data_i};
            end else if (latch_hi_i) begin
                pc_d = {data_i, pc_q[7:0]};
            end else if (load_i) begin
                pc_d = load_value_i;
            end else if (inc_i) begin
                pc_d = pc_q + 16'd1;
            end
        end
    end

    // PC register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/pc_address_unit.sv
// PC / address unit: reset-vector fetch FSM, program counter and external
// address mux. Optional feature macro: RESET_VECTOR_FETCH_EN (when defined,
// reset fetches the PC from VECTOR_ADDR/VECTOR_ADDR+1; otherwise reset enters
// run with pc=RESET_PC).
module pc_address_unit
    import pc_address_unit_pkg::*;
#(
    parameter logic [15:0] VECTOR_ADDR = DEFAULT_VECTOR_ADDR,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    pc_address_unit_if.slave    bus
);

`ifdef RESET_VECTOR_FETCH_EN
    localparam state_e      RESET_STATE    = S_VEC_LO;
    localparam logic [15:0] PC_RESET_VALUE = 16'h0000;
`else
    localparam state_e      RESET_STATE    = S_RUN;
    localparam logic [15:0] PC_RESET_VALUE = RESET_PC;
`endif

    state_e      state_q;
    state_e      state_d;
    logic [15:0] pc_q;
    logic [15:0] run_addr;
    logic [15:0] address_c;
    logic        rw_c;
    logic        hold_c;
    logic        latch_lo_c;
    logic        latch_hi_c;
    logic        load_c;
    logic        inc_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: two vector bytes, then run until reset
    always_comb begin
        state_d = state_q;
        if (bus.clk_enable) begin
            case (state_q)
                S_VEC_LO: state_d = S_VEC_HI;
                S_VEC_HI: state_d = S_RUN;
                S_RUN:    state_d = S_RUN;
                default:  state_d = RESET_STATE;
            endcase
        end
    end

    // Run-time address source mux; ALU address stays in page zero
    always_comb begin
        case (asel_e'(bus.address_select))
            ASEL_MEM: run_addr = bus.memory_address;
            ASEL_ALU: run_addr = {8'h00, bus.alu_result};
            default:  run_addr = pc_q;
        endcase
    end

    // Outputs and PC controls decoded from state; decode requests only act in run
    always_comb begin
        address_c  = run_addr;
        rw_c       = bus.rw_in;
        hold_c     = 1'b0;
        latch_lo_c = 1'b0;
        latch_hi_c = 1'b0;
        load_c     = 1'b0;
        inc_c      = 1'b0;
        case (state_q)
            S_VEC_LO: begin
                address_c  = VECTOR_ADDR;
                rw_c       = 1'b1;
                hold_c     = 1'b1;
                latch_lo_c = 1'b1;
            end
            S_VEC_HI: begin
                address_c  = VECTOR_ADDR + 16'd1;
                rw_c       = 1'b1;
                hold_c     = 1'b1;
                latch_hi_c = 1'b1;
            end
            default: begin
                load_c = bus.pc_load;
                inc_c  = bus.pc_enable & ~bus.pc_load;
            end
        endcase
        // Bus stays in read while reset is held, even when reset lands in run
        if (rst) begin
            rw_c = 1'b1;
        end
    end

    pc_register #(
        .RESET_VALUE (PC_RESET_VALUE)
    ) u_pc_register (
        .clk          (clk),
        .rst          (rst),
        .en_i         (bus.clk_enable),
        .latch_lo_i   (latch_lo_c),
        .latch_hi_i   (latch_hi_c),
        .load_i       (load_c),
        .inc_i        (inc_c),
        .load_value_i (bus.pc_load_value),
        .data_i       (bus.data_in),
        .pc_o         (pc_q)
    );

    assign bus.address_out = address_c;
    assign bus.rw_out      = rw_c;
    assign bus.core_hold   = hold_c;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_pc_address_unit.sv
// Directed bench for pc_address_unit with a behavioural model checked every
// cycle plus hand-computed literal expectations. Covers both settings of
// RESET_VECTOR_FETCH_EN.
module tb_pc_address_unit;

    localparam logic [15:0] VEC = 16'hFFFC;
    localparam logic [15:0] RPC = 16'h0000;
`ifdef RESET_VECTOR_FETCH_EN
    localparam int RESET_FETCHED = 0;
`else
    localparam int RESET_FETCHED = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   started = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pc_address_unit_if bus ();

    pc_address_unit #(
        .VECTOR_ADDR (VEC),
        .RESET_PC    (RPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: number of vector bytes fetched so far and the program counter
    int          m_fetched;
    logic [15:0] m_pc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fetched <= RESET_FETCHED;
            m_pc      <= (RESET_FETCHED == 2) ? RPC : 16'h0000;
        end else if (bus.clk_enable) begin
            if (m_fetched == 0) begin
                m_pc[7:0] <= bus.data_in;
                m_fetched <= 1;
            end else if (m_fetched == 1) begin
                m_pc[15:8] <= bus.data_in;
                m_fetched  <= 2;
            end else if (bus.pc_load) begin
                m_pc <= bus.pc_load_value;
            end else if (bus.pc_enable) begin
                m_pc <= m_pc + 16'd1;
            end
        end
    end

    function automatic logic [15:0] exp_addr();
        if (m_fetched == 0) return VEC;
        if (m_fetched == 1) return VEC + 16'd1;
        case (bus.address_select)
            2'd1:    return bus.memory_address;
            2'd2:    return {8'h00, bus.alu_result};
            default: return m_pc;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("cyc_addr", bus.address_out, exp_addr());
            check("cyc_pc",   bus.pc, m_pc);
            check("cyc_hold", {15'd0, bus.core_hold}, {15'd0, m_fetched != 2});
            check("cyc_rw",   {15'd0, bus.rw_out},
                  {15'd0, (rst || m_fetched != 2) ? 1'b1 : bus.rw_in});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.clk_enable     = 1'b1;
        bus.pc_enable      = 1'b0;
        bus.pc_load        = 1'b0;
        bus.pc_load_value  = 16'h0000;
        bus.address_select = 2'd0;
        bus.memory_address = 16'h0000;
        bus.alu_result     = 8'h00;
        bus.rw_in          = 1'b0;
        bus.data_in        = 8'h34;
        #1;
        rst     = 1'b1;
        started = 1'b1;
        step();
        step();

`ifdef RESET_VECTOR_FETCH_EN
        check("rst_addr", bus.address_out, 16'hFFFC);
        check("rst_hold", {15'd0, bus.core_hold}, 16'd1);
        check("rst_rw",   {15'd0, bus.rw_out}, 16'd1);
        check("rst_pc",   bus.pc, 16'h0000);
        rst = 1'b0;
        #1;
        check("vec_lo_addr", bus.address_out, 16'hFFFC);
        step();
        check("vec_hi_addr", bus.address_out, 16'hFFFD);
        check("vec_lo_pc",   bus.pc, 16'h0034);
        bus.data_in = 8'h12;
        step();
        check("vec_pc",   bus.pc, 16'h1234);
        check("vec_hold", {15'd0, bus.core_hold}, 16'd0);
        check("run_rw",   {15'd0, bus.rw_out}, 16'd0);
`else
        check("rst_pc",   bus.pc, 16'h0000);
        check("rst_hold", {15'd0, bus.core_hold}, 16'd0);
        check("rst_rw",   {15'd0, bus.rw_out}, 16'd1);
        rst = 1'b0;
        #1;
        check("run_rw", {15'd0, bus.rw_out}, 16'd0);
        bus.pc_load       = 1'b1;
        bus.pc_load_value = 16'h1234;
        step();
        bus.pc_load = 1'b0;
        check("load_pc", bus.pc, 16'h1234);
`endif
        check("run_addr_pc", bus.address_out, 16'h1234);

        // Wrap at 16'hFFFF
        bus.pc_load       = 1'b1;
        bus.pc_load_value = 16'hFFFF;
        step();
        bus.pc_load = 1'b0;
        check("load_ffff", bus.pc, 16'hFFFF);
        bus.pc_enable = 1'b1;
        step();
        bus.pc_enable = 1'b0;
        check("wrap_pc", bus.pc, 16'h0000);

        // Load wins over increment
        bus.pc_load       = 1'b1;
        bus.pc_load_value = 16'h0200;
        step();
        check("load_0200", bus.pc, 16'h0200);
        bus.pc_enable     = 1'b1;
        bus.pc_load_value = 16'h8000;
        step();
        bus.pc_load = 1'b0;
        check("load_prio", bus.pc, 16'h8000);
        step();
        check("inc_pc", bus.pc, 16'h8001);

        // clk_enable low holds the PC
        bus.clk_enable = 1'b0;
        step();
        step();
        check("ce_hold_pc", bus.pc, 16'h8001);
        bus.clk_enable = 1'b1;
        bus.pc_enable  = 1'b0;

        // Address source mux
        bus.address_select = 2'd2;
        bus.alu_result     = 8'hF3;
        bus.memory_address = 16'hABCD;
        #1;
        check("asel_alu", bus.address_out, 16'h00F3);
        bus.address_select = 2'd1;
        #1;
        check("asel_mem", bus.address_out, 16'hABCD);
        bus.address_select = 2'd3;
        #1;
        check("asel_pc3", bus.address_out, 16'h8001);
        bus.address_select = 2'd0;
        bus.rw_in          = 1'b1;
        #1;
        check("run_rw_hi", {15'd0, bus.rw_out}, 16'd1);
        bus.rw_in = 1'b0;

        // Reset pulsed mid-run
        bus.pc_load       = 1'b1;
        bus.pc_load_value = 16'h4000;
        step();
        bus.pc_load = 1'b0;
        check("load_4000", bus.pc, 16'h4000);
        rst = 1'b1;
        #1;
`ifdef RESET_VECTOR_FETCH_EN
        check("rerst_addr", bus.address_out, 16'hFFFC);
        check("rerst_hold", {15'd0, bus.core_hold}, 16'd1);
        check("rerst_pc",   bus.pc, 16'h0000);
        step();
        rst         = 1'b0;
        bus.data_in = 8'h56;
        step();
        check("refetch_hi_addr", bus.address_out, 16'hFFFD);
        check("refetch_lo_pc",   bus.pc, 16'h0056);
        // Stall in the high-byte fetch; decode requests must be ignored
        bus.clk_enable     = 1'b0;
        bus.data_in        = 8'h99;
        bus.address_select = 2'd1;
        bus.pc_load        = 1'b1;
        bus.pc_load_value  = 16'h7777;
        step();
        step();
        step();
        check("stall_addr", bus.address_out, 16'hFFFD);
        check("stall_pc",   bus.pc, 16'h0056);
        check("stall_hold", {15'd0, bus.core_hold}, 16'd1);
        bus.clk_enable = 1'b1;
        bus.data_in    = 8'hAB;
        step();
        bus.pc_load = 1'b0;
        check("refetch_pc",   bus.pc, 16'hAB56);
        check("refetch_hold", {15'd0, bus.core_hold}, 16'd0);
        check("refetch_mem",  bus.address_out, 16'hABCD);
        bus.address_select = 2'd0;
`else
        check("rerst_pc",   bus.pc, 16'h0000);
        check("rerst_hold", {15'd0, bus.core_hold}, 16'd0);
        check("rerst_rw",   {15'd0, bus.rw_out}, 16'd1);
        step();
        rst            = 1'b0;
        bus.clk_enable = 1'b0;
        bus.pc_enable  = 1'b1;
        step();
        step();
        step();
        check("stall_pc", bus.pc, 16'h0000);
        bus.clk_enable = 1'b1;
        step();
        bus.pc_enable = 1'b0;
        check("resume_pc",   bus.pc, 16'h0001);
        check("resume_addr", bus.address_out, 16'h0001);
`endif
        step();
        step();
        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_address_unit.md
PC_ADDRESS_UNIT -- requirements
Module: pc_address_unit

Interface
REQ-001 SHALL have parameter VECTOR_ADDR, default 16'hFFFC, giving the address of the reset-vector low byte.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, giving the PC reset value when vector fetch is compiled out.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port clk_enable, input, 1, qualifies every state update.
REQ-006 SHALL have port pc_enable, input, 1, increments the PC.
REQ-007 SHALL have port pc_load, input, 1, loads the PC from pc_load_value.
REQ-008 SHALL have port pc_load_value, input, 16, the jump target.
REQ-009 SHALL have port address_select, input, 2, selecting the address source: 0 PC, 1 memory_address, 2 ALU, 3 PC.
REQ-010 SHALL have port memory_address, input, 16, the decoded operand address.
REQ-011 SHALL have port alu_result, input, 8, the computed zero-page address.
REQ-012 SHALL have port rw_in, input, 1, the decode read/write request (1 = read).
REQ-013 SHALL have port data_in, input, 8, the external data bus read path.
REQ-014 SHALL have port address_out, output, 16, the external address bus.
REQ-015 SHALL have port rw_out, output, 1, the external read/write line.
REQ-016 SHALL have port pc, output, 16, the current program counter.
REQ-017 SHALL have port core_hold, output, 1, stalling decode while the vector fetch is in progress.

Function
REQ-018 SHALL implement the states S_VEC_LO, S_VEC_HI and S_RUN; all transitions require clk_enable=1.
REQ-019 In S_VEC_LO, the block SHALL drive address_out=VECTOR_ADDR, rw_out=1 and core_hold=1, latch pc[7:0]<=data_in, and move to S_VEC_HI.
REQ-020 In S_VEC_HI, the block SHALL drive address_out=VECTOR_ADDR+1, rw_out=1 and core_hold=1, latch pc[15:8]<=data_in, and move to S_RUN.
REQ-021 S_RUN SHALL be terminal until reset; in S_RUN, core_hold=0 and rw_out=rw_in.
REQ-022 In S_RUN, pc_load=1 SHALL set pc<=pc_load_value; otherwise pc_enable=1 SHALL set pc<=pc+1; pc_load SHALL win when both are asserted.
REQ-023 PC increment SHALL be modulo 2^16, so 16'hFFFF wraps to 16'h0000.
REQ-024 address_out SHALL be combinational from registered state: sel 0 or 3 gives pc, sel 1 gives memory_address, sel 2 gives {8'h00, alu_result}, so the ALU address wraps within page zero.
REQ-025 pc_enable, pc_load, address_select and rw_in SHALL be ignored outside S_RUN.
REQ-026 With clk_enable=0, state and pc SHALL hold, and outputs SHALL keep being driven from the held state.
REQ-027 Latency: a pc change SHALL be visible on pc and address_out one enabled edge after the request.

Reset
REQ-028 rst=1 SHALL asynchronously force state=S_VEC_LO (or S_RUN when compiled out), pc=16'h0000 (or RESET_PC), core_hold=1 (or 0), and rw_out=1.
REQ-029 Reset asserted mid-fetch or mid-run SHALL abort the operation and restart from the reset state on the first enabled edge after release.

Configuration
REQ-030 The macro RESET_VECTOR_FETCH_EN SHALL control the vector fetch.
- Defined: the S_VEC_LO/S_VEC_HI sequence is present.
- Undefined: reset enters S_RUN directly with pc=RESET_PC and core_hold tied to 0; data_in is unused.

Structure
REQ-031 The address_select encodings (ASEL_PC, ASEL_MEM, ASEL_ALU) and the default vector constant SHALL live in a shared include header used by both decode and this block.
REQ-032 A sub-module pc_register SHALL hold the 16-bit PC with load/increment/byte-latch controls; the FSM and the address mux SHALL stay in pc_address_unit.

Verification
REQ-033 The bench SHALL cover: release rst with data_in=8'h34 then 8'h12 -> address_out=FFFC then FFFD, then pc=16'h1234, core_hold=0.
REQ-034 The bench SHALL cover: pc=16'hFFFF, pc_enable=1 for one enabled edge -> pc=16'h0000.
REQ-035 The bench SHALL cover: pc=16'h0200, pc_load=1 and pc_enable=1 with pc_load_value=16'h8000 -> pc=16'h8000, not 16'h0201.
REQ-036 The bench SHALL cover: address_select=2, alu_result=8'hF3, memory_address=16'hABCD -> address_out=16'h00F3; address_select=1 -> address_out=16'hABCD.
REQ-037 The bench SHALL cover: clk_enable=0 for 3 edges during S_VEC_HI -> address_out holds FFFD and pc is unchanged; the fetch completes once clk_enable=1.
REQ-038 The bench SHALL cover: rst pulsed while in S_RUN with pc=16'h4000 -> immediately S_VEC_LO, address_out=FFFC, core_hold=1.
